// File: rtl/test_sram_pkg.sv
// Shared AHB defines for the test SRAM slave.
// Holds the bus-width constants and the default memory geometry; the
// test_sram parameters take their defaults from here.
package test_sram_pkg;

    localparam int unsigned AhbDataWidth    = 32;
    localparam int unsigned AhbAddrWidth    = 32;
    localparam int unsigned SramDepth       = 4096;
    localparam int unsigned SramWaitStates  = 0;

endpackage

// File: rtl/test_sram.sv
// AHB-lite style single-port SRAM slave with a programmable number of wait states.
//
// Ports:
//   HCLK     in   single clock
//   HRESETn  in   synchronous active-low reset
//   HSEL     in   slave select, qualifies the address phase
//   HADDR    in   byte address; word index is HADDR[log2(DEPTH)+1:2]
//   HWRITE   in   1 = write transfer, 0 = read transfer
//   HWDATA   in   write data, sampled on the edge that ends the data phase
//   HREADY   out  data phase completes when high; idle bus holds it high
//   HRDATA   out  read data, valid from the first read data-phase cycle
module test_sram
    import test_sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = AhbDataWidth,
    parameter int unsigned ADDR_WIDTH  = AhbAddrWidth,
    parameter int unsigned DEPTH       = SramDepth,
    parameter int unsigned WAIT_STATES = SramWaitStates
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int unsigned IdxWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntWidth = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IdxWidth-1:0]   idx_q, idx_d;
    logic                  write_q, write_d;
    logic                  valid_q, valid_d;
    logic [CntWidth-1:0]   wait_cnt_q, wait_cnt_d;
    logic                  hready_q, hready_d;
    logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;

    logic [IdxWidth-1:0]   addr_idx;
    logic                  accept;
    logic                  mem_we;
    logic                  raw_hit;
    logic                  unused_haddr;

    assign addr_idx     = HADDR[IdxWidth+1:2];
    // Byte-lane bits and bits above the index are don't-care: addresses wrap.
    assign unused_haddr = ^{HADDR[1:0], HADDR[ADDR_WIDTH-1:IdxWidth+2]};

    assign accept  = HSEL && hready_q;
    assign mem_we  = valid_q && hready_q && write_q;
    // A read accepted on the same edge a write to that word commits must see
    // the new data, so bypass the array with HWDATA.
    assign raw_hit = mem_we && (idx_q == addr_idx);

    always_comb begin
        idx_d      = idx_q;
        write_d    = write_q;
        valid_d    = valid_q;
        wait_cnt_d = wait_cnt_q;
        hready_d   = hready_q;
        hrdata_d   = hrdata_q;

        if (hready_q) begin
            // Previous data phase (if any) ends here; HSEL=0 makes the next cycle idle.
            valid_d = accept;
            if (accept) begin
                idx_d      = addr_idx;
                write_d    = HWRITE;
                wait_cnt_d = CntWidth'(WAIT_STATES);
                hready_d   = (WAIT_STATES == 0);
                if (!HWRITE) begin
                    hrdata_d = raw_hit ? HWDATA : mem[addr_idx];
                end
            end
        end else begin
            // Wait states: index and direction held, no new address phase taken.
            wait_cnt_d = wait_cnt_q - CntWidth'(1);
            hready_d   = (wait_cnt_q == CntWidth'(1));
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            idx_q      <= '0;
            write_q    <= 1'b0;
            valid_q    <= 1'b0;
            wait_cnt_q <= '0;
            hready_q   <= 1'b1;
            hrdata_q   <= '0;
        end else begin
            idx_q      <= idx_d;
            write_q    <= write_d;
            valid_q    <= valid_d;
            wait_cnt_q <= wait_cnt_d;
            hready_q   <= hready_d;
            hrdata_q   <= hrdata_d;
        end
    end

    // Array is never cleared; reset only blocks a pending write.
    always_ff @(posedge HCLK) begin
        if (HRESETn && mem_we) begin
            mem[idx_q] <= HWDATA;
        end
    end

    assign HREADY = hready_q;
    assign HRDATA = hrdata_q;

endmodule

// File: tb/tb_test_sram.sv
// Self-checking bench for test_sram: one zero-wait instance and one two-wait instance
// sharing the bus signals, each with its own select. Expected read data is pushed
// to a scoreboard queue when a read address phase is driven and popped when the
// data phase completes.
module tb_test_sram;

    logic        hclk;
    logic        hresetn;
    logic        hsel0, hsel2;
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hready0, hready2;
    logic [31:0] hrdata0, hrdata2;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] sb [$];

    test_sram #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH      (4096),
        .WAIT_STATES(0)
    ) u_dut0 (
        .HCLK   (hclk),
        .HRESETn(hresetn),
        .HSEL   (hsel0),
        .HADDR  (haddr),
        .HWRITE (hwrite),
        .HWDATA (hwdata),
        .HREADY (hready0),
        .HRDATA (hrdata0)
    );

    test_sram #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH      (4096),
        .WAIT_STATES(2)
    ) u_dut2 (
        .HCLK   (hclk),
        .HRESETn(hresetn),
        .HSEL   (hsel2),
        .HADDR  (haddr),
        .HWRITE (hwrite),
        .HWDATA (hwdata),
        .HREADY (hready2),
        .HRDATA (hrdata2)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", tag, obs, exp);
        end
    endtask

    task automatic set_sel(input bit slow, input logic v);
        if (slow) hsel2 = v;
        else      hsel0 = v;
    endtask

    function automatic logic get_ready(input bit slow);
        return slow ? hready2 : hready0;
    endfunction

    function automatic logic [31:0] get_rdata(input bit slow);
        return slow ? hrdata2 : hrdata0;
    endfunction

    // Count low-HREADY cycles of the current data phase (bounded).
    task automatic wait_ready(input bit slow, input int exp_waits, input string tag);
        int waits = 0;
        while (!get_ready(slow) && waits < 16) begin
            waits++;
            @(negedge hclk);
        end
        chk({tag, "/waits"}, 32'(waits), 32'(exp_waits));
    endtask

    task automatic pop_cmp(input bit slow, input string tag);
        logic [31:0] e;
        e = (sb.size() != 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        chk({tag, "/rdata"}, get_rdata(slow), e);
    endtask

    // Single non-pipelined transfer; for reads 'data' is the expected value.
    task automatic xfer(input bit slow, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input int exp_waits, input string tag);
        set_sel(slow, 1'b1);
        haddr  = addr;
        hwrite = wr;
        if (!wr) sb.push_back(data);
        @(negedge hclk);
        set_sel(slow, 1'b0);
        hwrite = 1'b0;
        if (wr) hwdata = data;
        wait_ready(slow, exp_waits, tag);
        if (!wr) pop_cmp(slow, tag);
        @(negedge hclk);
    endtask

    initial begin
        hresetn = 1'b0;
        hsel0   = 1'b0;
        hsel2   = 1'b0;
        haddr   = '0;
        hwrite  = 1'b0;
        hwdata  = '0;
        repeat (3) @(negedge hclk);
        chk("rst/hready0", 32'(hready0), 32'd1);
        chk("rst/hrdata0", hrdata0, 32'h0);
        chk("rst/hready2", 32'(hready2), 32'd1);
        chk("rst/hrdata2", hrdata2, 32'h0);
        hresetn = 1'b1;
        @(negedge hclk);

        // Preload zero-wait instance
        xfer(1'b0, 1'b1, 32'h0, 32'h0000_0013, 0, "pre0");
        xfer(1'b0, 1'b1, 32'h4, 32'h1111_1111, 0, "pre1");
        xfer(1'b0, 1'b1, 32'h8, 32'h2222_2222, 0, "pre2");
        xfer(1'b0, 1'b1, 32'hC, 32'h3333_3333, 0, "pre3");

        xfer(1'b0, 1'b0, 32'h0, 32'h0000_0013, 0, "rd0");

        // Back-to-back write then read of the same word
        hsel0  = 1'b1;
        haddr  = 32'h10;
        hwrite = 1'b1;
        @(negedge hclk);
        hwdata = 32'hDEAD_BEEF;
        hwrite = 1'b0;
        haddr  = 32'h10;
        sb.push_back(32'hDEAD_BEEF);
        chk("raw/wr_ready", 32'(hready0), 32'd1);
        @(negedge hclk);
        hsel0 = 1'b0;
        wait_ready(1'b0, 0, "raw");
        pop_cmp(1'b0, "raw");
        @(negedge hclk);
        xfer(1'b0, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, "rd10");

        // Address wrap and ignored byte bits
        xfer(1'b0, 1'b0, 32'h4000, 32'h0000_0013, 0, "wrap");
        xfer(1'b0, 1'b0, 32'h4007, 32'h1111_1111, 0, "wrap_b");

        // Unselected write: no effect, idle cycles hold HRDATA
        hsel0  = 1'b0;
        hwrite = 1'b1;
        haddr  = 32'h8;
        hwdata = 32'hBAD0_BAD0;
        repeat (2) @(negedge hclk);
        chk("idle/hready", 32'(hready0), 32'd1);
        chk("idle/hold", hrdata0, 32'h1111_1111);
        hwrite = 1'b0;
        xfer(1'b0, 1'b0, 32'h8, 32'h2222_2222, 0, "nosel");

        // Two-wait instance
        xfer(1'b1, 1'b1, 32'h4, 32'hCAFE_F00D, 2, "ws_wr1");
        xfer(1'b1, 1'b1, 32'h8, 32'h55AA_55AA, 2, "ws_wr2");
        xfer(1'b1, 1'b0, 32'h4, 32'hCAFE_F00D, 2, "ws_rd1");

        // Address phase held through wait states, taken when HREADY returns
        hsel2  = 1'b1;
        haddr  = 32'h4;
        hwrite = 1'b0;
        sb.push_back(32'hCAFE_F00D);
        @(negedge hclk);
        haddr = 32'h8;
        sb.push_back(32'h55AA_55AA);
        wait_ready(1'b1, 2, "pipe1");
        pop_cmp(1'b1, "pipe1");
        @(negedge hclk);
        hsel2 = 1'b0;
        wait_ready(1'b1, 2, "pipe2");
        pop_cmp(1'b1, "pipe2");
        @(negedge hclk);
        chk("ws_idle/hready", 32'(hready2), 32'd1);

        // Reset during a write data phase
        hsel0  = 1'b1;
        haddr  = 32'hC;
        hwrite = 1'b1;
        @(negedge hclk);
        hsel0   = 1'b0;
        hwrite  = 1'b0;
        hwdata  = 32'hFFFF_FFFF;
        hresetn = 1'b0;
        @(negedge hclk);
        chk("midrst/hready0", 32'(hready0), 32'd1);
        chk("midrst/hrdata0", hrdata0, 32'h0);
        chk("midrst/hrdata2", hrdata2, 32'h0);
        hresetn = 1'b1;
        @(negedge hclk);
        xfer(1'b0, 1'b0, 32'hC, 32'h3333_3333, 0, "midrst_tgt");
        xfer(1'b0, 1'b0, 32'h0, 32'h0000_0013, 0, "midrst_w0");
        xfer(1'b0, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, "midrst_w4");
        xfer(1'b1, 1'b0, 32'h8, 32'h55AA_55AA, 2, "midrst_ws");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/test_sram.md
TEST_SRAM -- requirements
Module: test_sram

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the HWDATA and HRDATA data buses and of each memory word.
REQ-002 Parameter ADDR_WIDTH, default 32: width of HADDR.
REQ-003 Parameter DEPTH, default 4096: number of memory words.
REQ-004 Parameter WAIT_STATES, default 0: number of extra data-phase cycles with HREADY held low.
REQ-005 HCLK  input  1  single clock for the whole block.
REQ-006 HRESETn  input  1  reset, synchronous and active-low.
REQ-007 HSEL  input  1  slave select; qualifies the address phase.
REQ-008 HADDR  input  ADDR_WIDTH  byte address.
REQ-009 HWRITE  input  1  1 = write transfer, 0 = read transfer.
REQ-010 HWDATA  input  DATA_WIDTH  write data, valid during the data phase.
REQ-011 HREADY  output  1  data phase completes when high.
REQ-012 HRDATA  output  DATA_WIDTH  read data, valid when HREADY is high in a read data phase.

Function
REQ-013 Storage SHALL be an unpacked array named "mem" of DEPTH x DATA_WIDTH words, so the bench can preload it hierarchically with readmemh and dump it.
REQ-014 The word index SHALL be HADDR[log2(DEPTH)+1:2]; HADDR[1:0] and the bits above the index SHALL be ignored, so addresses wrap modulo DEPTH*4.
REQ-015 An address phase SHALL be accepted on a rising HCLK edge when HSEL=1 and HREADY=1; on acceptance the block registers the word index, HWRITE and a valid flag.
REQ-016 Read data phase: HRDATA SHALL present mem[index] from the first data-phase cycle onward; zero-wait latency is 1 cycle after the address phase.
REQ-017 Write data phase: mem[index] SHALL be loaded with HWDATA on the rising edge that ends the data phase (HREADY=1).
REQ-018 With WAIT_STATES=N, HREADY SHALL be low for exactly N cycles at the start of every data phase and then high for one cycle; an idle bus keeps HREADY=1.
REQ-019 While HREADY=0, a new address phase SHALL NOT be accepted, and the registered index and direction SHALL be held.
REQ-020 Read after write to the same index in back-to-back transfers SHALL return the newly written data (forward HWDATA or stall; the data must be correct).
REQ-021 HSEL=0 during an address phase SHALL leave mem unchanged and make the next cycle idle; in an idle cycle HRDATA SHALL hold its last value.
REQ-022 Full 32-bit word writes only; there is no byte-lane masking.

Reset
REQ-023 While HRESETn=0 at a rising edge: HREADY<=1, HRDATA<=0, valid flag<=0, wait counter<=0.
REQ-024 mem SHALL NOT be cleared by reset; preloaded contents survive reset.
REQ-025 Reset asserted during a data phase SHALL abort it, and no write SHALL occur on that edge.

Structure
REQ-026 DATA_WIDTH, DEPTH and the bus-width constants SHALL reside in the shared AHB defines package; log2(DEPTH) SHALL be derived via a localparam.
REQ-027 The design SHALL be a single module with no sub-modules; the wait-state counter is inline.

Verification
REQ-028 Preload mem[0]=32'h00000013, then read HADDR=0 with WAIT_STATES=0 -> HRDATA=32'h00000013 one cycle later with HREADY=1.
REQ-029 Write 32'hDEADBEEF to HADDR=32'h10, then read 32'h10 back-to-back -> HRDATA=32'hDEADBEEF.
REQ-030 Read HADDR=32'h4000 with DEPTH=4096 -> data from mem[0] (wrap).
REQ-031 WAIT_STATES=2, read HADDR=4 -> HREADY low for 2 cycles, then high with HRDATA=mem[1].
REQ-032 Write with HSEL=0 to HADDR=8 -> mem[2] unchanged.
REQ-033 Assert HRESETn=0 mid-write -> HREADY=1, HRDATA=0, target word unchanged, other preloaded words intact.
